// File: rtl/aes_bridge_pkg.sv
// Shared constants and state encoding for the AES FIFO bridge.
// Imported by the bridge top and its ciphertext serializer.
package aes_bridge_pkg;

   localparam int KEY_WORDS = 8;
   localparam int PT_WORDS  = 8;
   localparam int CT_WORDS  = 8;
   localparam int BLK_W     = 128;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_LOAD  = S_LOAD,
      ST_START = S_START,
      ST_WAIT  = S_WAIT,
      ST_DRAIN = S_DRAIN,
      ST_DONE  = S_DONE
   } state_t;

endpackage

// File: rtl/aes_fifo_bridge_serializer.sv
// Holds one 128-bit ciphertext and presents it MS word first,
// advancing one word per accepted push.
module aes_word_serializer
   import aes_bridge_pkg::*;
#(
   parameter int WORD_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [BLK_W-1:0]  i_data,
   input  logic              i_adv,
   output logic [WORD_W-1:0] o_data,
   output logic              o_last
);

   logic [BLK_W-1:0] r_ct;
   logic [2:0]       r_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ct  <= '0;
         r_idx <= '0;
      end else if (i_load) begin
         r_ct  <= i_data;
         r_idx <= '0;
      end else if (i_adv) begin
         r_ct  <= {r_ct[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
         r_idx <= r_idx + 3'd1;
      end
   end

   assign o_data = r_ct[BLK_W-1 -: WORD_W];
   assign o_last = (r_idx == 3'(CT_WORDS - 1));

endmodule

// File: rtl/aes_fifo_bridge.sv
// Bridges input FIFO -> AES core -> output FIFO: gathers key and
// plaintext, runs one encryption, streams the ciphertext out.
module aes_fifo_bridge
   import aes_bridge_pkg::*;
#(
   parameter int WORD_W      = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk_main_a0,
   input  logic              rst_main_n_sync,
   input  logic              ififo_empty,
   input  logic [WORD_W-1:0] ififo_dout,
   output logic              ififo_rd_en,
   input  logic              ofifo_full,
   output logic              ofifo_wr_en,
   output logic [WORD_W-1:0] ofifo_din,
   output logic              aes_start,
   output logic [BLK_W-1:0]  aes_key,
   output logic [BLK_W-1:0]  aes_pt,
   input  logic              aes_done,
   input  logic [BLK_W-1:0]  aes_ct,
   output logic              busy,
   output logic              blk_done,
   output logic [15:0]       blk_count,
   output logic              timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0] W_LAST = 4'(KEY_WORDS + PT_WORDS - 1);

   state_t           r_state;
   logic [3:0]       r_widx;
   logic [WD_W-1:0]  r_wdog;
   logic [BLK_W-1:0] r_key;
   logic [BLK_W-1:0] r_pt;
   logic [15:0]      r_blk_count;
   logic             r_tmo;

   logic w_pop;
   logic w_push;
   logic w_load_ct;
   logic w_last;

   assign w_pop     = (r_state == ST_LOAD) & ~ififo_empty;
   assign w_push    = (r_state == ST_DRAIN) & ~ofifo_full;
   assign w_load_ct = (r_state == ST_WAIT) & aes_done;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
      if (!rst_main_n_sync) begin
         r_state     <= ST_IDLE;
         r_widx      <= '0;
         r_wdog      <= '0;
         r_key       <= '0;
         r_pt        <= '0;
         r_blk_count <= '0;
         r_tmo       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!ififo_empty) r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (w_pop) begin
                  // Shift in MS word first so word 0 lands in [127:112].
                  if (r_widx < 4'(KEY_WORDS))
                     r_key <= {r_key[BLK_W-WORD_W-1:0], ififo_dout};
                  else
                     r_pt  <= {r_pt[BLK_W-WORD_W-1:0], ififo_dout};
                  r_widx <= r_widx + 4'd1;
                  if (r_widx == W_LAST) r_state <= ST_START;
               end
            end
            ST_START: begin
               r_wdog  <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (aes_done) begin
                  r_state <= ST_DRAIN;
               end else if (r_wdog == WD_MAX) begin
                  r_tmo   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_push && w_last) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_blk_count <= r_blk_count + 16'd1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   aes_word_serializer #(
      .WORD_W (WORD_W)
   ) u_ser (
      .i_clk   (clk_main_a0),
      .i_rst_n (rst_main_n_sync),
      .i_load  (w_load_ct),
      .i_data  (aes_ct),
      .i_adv   (w_push),
      .o_data  (ofifo_din),
      .o_last  (w_last)
   );

   assign ififo_rd_en = w_pop;
   assign ofifo_wr_en = w_push;
   assign aes_start   = (r_state == ST_START);
   assign aes_key     = r_key;
   assign aes_pt      = r_pt;
   assign busy        = (r_state != ST_IDLE);
   assign blk_done    = (r_state == ST_DONE);
   assign blk_count   = r_blk_count;
   assign timeout_err = r_tmo;

endmodule

// File: tb/tb_aes_fifo_bridge.sv
// Randomized bench for aes_fifo_bridge with FIFO, core and
// ciphertext-stream models kept as queues.
module tb_aes_fifo_bridge;

   localparam int TMO = 16;
   localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ififo_empty;
   logic [15:0]  ififo_dout;
   logic         ififo_rd_en;
   logic         ofifo_full;
   logic         ofifo_wr_en;
   logic [15:0]  ofifo_din;
   logic         aes_start;
   logic [127:0] aes_key;
   logic [127:0] aes_pt;
   logic         aes_done;
   logic [127:0] aes_ct;
   logic         busy;
   logic         blk_done;
   logic [15:0]  blk_count;
   logic         timeout_err;

   always #5 clk = ~clk;

   aes_fifo_bridge #(
      .WORD_W      (16),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_main_a0     (clk),
      .rst_main_n_sync (rst_n),
      .ififo_empty     (ififo_empty),
      .ififo_dout      (ififo_dout),
      .ififo_rd_en     (ififo_rd_en),
      .ofifo_full      (ofifo_full),
      .ofifo_wr_en     (ofifo_wr_en),
      .ofifo_din       (ofifo_din),
      .aes_start       (aes_start),
      .aes_key         (aes_key),
      .aes_pt          (aes_pt),
      .aes_done        (aes_done),
      .aes_ct          (aes_ct),
      .busy            (busy),
      .blk_done        (blk_done),
      .blk_count       (blk_count),
      .timeout_err     (timeout_err)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] in_q[$];
   logic [15:0] exp_q[$];

   bit tog_mode = 0, tog = 0, full_mode = 0, full_used = 0;
   bit hang = 0, rnd_mode = 0, core_pend = 0, prev_done = 0;
   int full_left = 0, blk_push = 0, pops = 0, pushes = 0;
   int done_cnt = 0, starts = 0, core_lat = 0, fixed_lat = -1;
   int cyc = 0, start_cyc = 0, done_cyc = 0;
   logic [127:0] cap_key = '0, cap_pt = '0;

   // Stand-in for the AES core: real FIPS answer for the known
   // vector, otherwise a cheap keyed mix of the plaintext.
   function automatic logic [127:0] core_fn(input logic [127:0] k,
                                            input logic [127:0] p);
      if (k == FK && p == FP) return FC;
      return k ^ {p[63:0], p[127:64]} ^
             128'h0123456789abcdeffedcba9876543210;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (full_mode && !full_used && blk_push == 2) begin
         full_left = 5;
         full_used = 1;
      end
      tog = ~tog;
      ififo_empty = (in_q.size() == 0) || (tog_mode && tog) ||
                    (rnd_mode && $urandom_range(0, 3) == 0);
      ififo_dout  = ififo_empty ? 16'($urandom) : in_q[0];
      ofifo_full  = (full_left > 0) ||
                    (rnd_mode && $urandom_range(0, 3) == 0);
      aes_done    = core_pend && !hang && core_lat == 0;
      aes_ct      = aes_done ? core_fn(cap_key, cap_pt) : rnd128();
      #1;
      if (ififo_rd_en) begin
         check("pop_empty", 128'(ififo_empty), 128'(0));
         if (!ififo_empty) begin
            void'(in_q.pop_front());
            pops++;
         end
      end
      if (ofifo_wr_en) begin
         check("push_full", 128'(ofifo_full), 128'(0));
         pushes++;
         blk_push++;
         if (exp_q.size() == 0)
            check("push_extra", 128'(1), 128'(0));
         else
            check("ct_word", 128'(ofifo_din), 128'(exp_q.pop_front()));
      end
      if (full_left > 0) begin
         check("stall_wr", 128'(ofifo_wr_en), 128'(0));
         if (exp_q.size() > 0)
            check("stall_din", 128'(ofifo_din), 128'(exp_q[0]));
         full_left--;
      end
      if (aes_start) begin
         starts++;
         start_cyc = cyc;
         core_pend = 1;
         core_lat  = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 6);
         cap_key   = aes_key;
         cap_pt    = aes_pt;
      end else if (core_pend && !hang) begin
         if (aes_done) core_pend = 0;
         else core_lat--;
      end
      if (blk_done) begin
         check("done_pulse", 128'(prev_done), 128'(0));
         done_cnt++;
         done_cyc = cyc;
         blk_push = 0;
      end
      prev_done = blk_done;
   endtask

   task automatic feed(input logic [127:0] k, input logic [127:0] p,
                       input bit expect_ct);
      logic [127:0] ct;
      for (int i = 0; i < 8; i++) in_q.push_back(k[127-16*i -: 16]);
      for (int i = 0; i < 8; i++) in_q.push_back(p[127-16*i -: 16]);
      if (expect_ct) begin
         ct = core_fn(k, p);
         for (int i = 0; i < 8; i++) exp_q.push_back(ct[127-16*i -: 16]);
      end
   endtask

   task automatic run_blocks(input int n, input int budget);
      int tgt;
      int b;
      tgt = done_cnt + n;
      b = 0;
      while (done_cnt < tgt && b < budget) begin
         cycle();
         b++;
      end
      check("blocks_done", 128'(done_cnt), 128'(tgt));
      cycle();
   endtask

   initial begin
      int p0, pu0, d0, s0, n, b;
      logic [15:0] c0;
      rst_n       = 1'b0;
      ififo_empty = 1'b1;
      ififo_dout  = '0;
      ofifo_full  = 1'b0;
      aes_done    = 1'b0;
      aes_ct      = '0;
      repeat (3) cycle();
      check("rst_busy",  128'(busy), 128'(0));
      check("rst_count", 128'(blk_count), 128'(0));
      check("rst_tmo",   128'(timeout_err), 128'(0));
      check("rst_key",   aes_key, 128'(0));
      check("rst_din",   128'(ofifo_din), 128'(0));
      rst_n = 1'b1;
      repeat (2) cycle();

      // Known-answer block with fixed core latency.
      fixed_lat = 3;
      p0 = pops;
      feed(FK, FP, 1);
      run_blocks(1, 200);
      check("t1_key", cap_key, FK);
      check("t1_pt", cap_pt, FP);
      check("t1_pops", 128'(pops - p0), 128'(16));
      check("t1_latency", 128'(done_cyc - start_cyc), 128'(13));
      check("t1_count", 128'(blk_count), 128'(1));
      fixed_lat = -1;

      // Input FIFO empty every other cycle.
      tog_mode = 1;
      p0 = pops;
      feed(FK, FP, 1);
      run_blocks(1, 300);
      tog_mode = 0;
      check("t2_key", cap_key, FK);
      check("t2_pt", cap_pt, FP);
      check("t2_pops", 128'(pops - p0), 128'(16));
      check("t2_count", 128'(blk_count), 128'(2));

      // Output FIFO full for 5 cycles after two words.
      full_mode = 1;
      full_used = 0;
      pu0 = pushes;
      feed(FK, FP, 1);
      run_blocks(1, 300);
      full_mode = 0;
      check("t3_pushes", 128'(pushes - pu0), 128'(8));
      check("t3_stalled", 128'(full_used), 128'(1));
      check("t3_count", 128'(blk_count), 128'(3));

      // Core hangs: watchdog abort.
      hang = 1;
      pu0 = pushes;
      d0 = done_cnt;
      s0 = starts;
      c0 = blk_count;
      feed(rnd128(), rnd128(), 0);
      b = 0;
      while (starts == s0 && b < 100) begin
         cycle();
         b++;
      end
      check("t4_start", 128'(starts - s0), 128'(1));
      n = 0;
      b = 0;
      do begin
         cycle();
         b++;
         if (busy) n++;
      end while (busy && b < 100);
      check("t4_wait_cycles", 128'(n), 128'(TMO));
      check("t4_tmo_err", 128'(timeout_err), 128'(1));
      check("t4_pushes", 128'(pushes - pu0), 128'(0));
      check("t4_done", 128'(done_cnt - d0), 128'(0));
      check("t4_count", 128'(blk_count), 128'(c0));
      hang = 0;
      core_pend = 0;
      repeat (5) cycle();
      check("t4_sticky", 128'(timeout_err), 128'(1));
      check("t4_idle", 128'(busy), 128'(0));

      // Reset in the middle of LOAD.
      p0 = pops;
      feed(rnd128(), rnd128(), 1);
      b = 0;
      while (pops - p0 < 10 && b < 100) begin
         cycle();
         b++;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_busy", 128'(busy), 128'(0));
      check("t5_rd", 128'(ififo_rd_en), 128'(0));
      check("t5_wr", 128'(ofifo_wr_en), 128'(0));
      check("t5_start", 128'(aes_start), 128'(0));
      check("t5_key", aes_key, 128'(0));
      check("t5_pt", aes_pt, 128'(0));
      check("t5_done", 128'(blk_done), 128'(0));
      check("t5_count", 128'(blk_count), 128'(0));
      check("t5_tmo", 128'(timeout_err), 128'(0));
      check("t5_din", 128'(ofifo_din), 128'(0));
      in_q.delete();
      exp_q.delete();
      core_pend = 0;
      blk_push  = 0;
      prev_done = 0;
      repeat (2) cycle();
      rst_n = 1'b1;
      feed(rnd128(), rnd128(), 1);
      feed(rnd128(), rnd128(), 1);
      run_blocks(2, 400);
      check("t5_count2", 128'(blk_count), 128'(2));
      check("t5_drained", 128'(exp_q.size()), 128'(0));

      // Counter wrap.
      force dut.r_blk_count = 16'hFFFF;
      @(posedge clk);
      #1 release dut.r_blk_count;
      check("t6_preload", 128'(blk_count), 128'(16'hFFFF));
      d0 = done_cnt;
      feed(rnd128(), rnd128(), 1);
      run_blocks(1, 300);
      repeat (3) cycle();
      check("t6_wrap", 128'(blk_count), 128'(0));
      check("t6_pulses", 128'(done_cnt - d0), 128'(1));

      // Back-to-back random blocks with random FIFO gating.
      rnd_mode = 1;
      for (int i = 0; i < 6; i++) feed(rnd128(), rnd128(), 1);
      run_blocks(6, 3000);
      rnd_mode = 0;
      repeat (3) cycle();
      check("t7_drained", 128'(exp_q.size()), 128'(0));
      check("t7_in_empty", 128'(in_q.size()), 128'(0));
      check("t7_count", 128'(blk_count), 128'(6));
      check("t7_tmo", 128'(timeout_err), 128'(0));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got stuck exp finish");
      $fatal(1, "bench time limit");
   end

endmodule
